vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk_i cycles per pixel (100 MHz to 25 MHz); legal range 2..16.
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal pixel counts per phase.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical line counts per phase.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  system clock, 100 MHz.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 en_i  input  1  run enable; low holds the block in its reset state.
REQ-008 pix_tick_o  output  1  one-clk_i-cycle pulse marking a new pixel position.
REQ-009 hsync_o  output  1  horizontal sync, active-low.
REQ-010 vsync_o  output  1  vertical sync, active-low.
REQ-011 active_o  output  1  high while the position is inside the visible area.
REQ-012 x_o  output  10  raw horizontal count, 0..H_TOTAL-1.
REQ-013 y_o  output  10  raw vertical count, 0..V_TOTAL-1.
REQ-014 line_start_o  output  1  one-cycle pulse when x_o becomes 0.
REQ-015 frame_start_o  output  1  one-cycle pulse when x_o and y_o both become 0.

Function
REQ-016 SHALL define H_TOTAL = sum of horizontal parameters (800) and V_TOTAL = sum of vertical parameters (525).
REQ-017 Prescaler SHALL count 0..CLK_DIV-1 while en_i is high; on the edge where it wraps to 0, pix_tick_o SHALL register high for exactly one cycle.
REQ-018 On every edge that sets pix_tick_o, h_cnt SHALL advance by 1 and wrap from H_TOTAL-1 to 0; v_cnt SHALL advance only on that h wrap, and wrap from V_TOTAL-1 to 0.
REQ-019 Horizontal FSM states SHALL be H_ACT (h 0..639), H_FP (640..655), H_SYNC (656..751) and H_BP (752..799); each transition occurs on the tick where h_cnt enters the next range.
REQ-020 Vertical FSM states SHALL be V_ACT (v 0..479), V_FP (480..489), V_SYNC (490..491) and V_BP (492..524), advanced on the h wrap.
REQ-021 hsync_o SHALL be 0 only in H_SYNC; vsync_o SHALL be 0 only in V_SYNC; active_o SHALL be 1 only in H_ACT and V_ACT together.
REQ-022 All outputs SHALL be registered and SHALL change only on the same edge that sets pix_tick_o, with zero extra latency relative to pix_tick_o.
REQ-023 line_start_o and frame_start_o SHALL be high only in cycles where pix_tick_o is high.
REQ-024 en_i low SHALL, on the next edge, force the prescaler, counters, FSMs and outputs to their reset values; after en_i rises again, the first pix_tick_o SHALL follow CLK_DIV edges later.
REQ-025 rst_i SHALL take priority over en_i; reset mid-frame SHALL abandon the frame with no partial sync pulse extension.

Reset
REQ-026 Reset values: prescaler 0; h_cnt = H_TOTAL-1; v_cnt = V_TOTAL-1; FSMs in H_BP and V_BP; pix_tick_o 0; hsync_o 1; vsync_o 1; active_o 0; line_start_o 0; frame_start_o 0; x_o = H_TOTAL-1; y_o = V_TOTAL-1.
REQ-027 The first tick after reset SHALL present x_o=0, y_o=0, active_o=1, with line_start_o and frame_start_o both pulsing.

Structure
REQ-028 Shared package vga_pkg SHALL hold the timing defaults, H_TOTAL/V_TOTAL and the H/V state encodings.
REQ-029 The prescaler SHALL be sub-module vga_pix_tick (clk_i, rst_i, en_i, tick_o), parameterised by CLK_DIV.

Verification
REQ-030 Reset release with en_i=1, CLK_DIV=4 -> first pix_tick_o on cycle 4; x_o=0, y_o=0, active_o=1, frame_start_o=1; thereafter ticks every 4 cycles.
REQ-031 One full line -> hsync_o low for exactly 96 ticks starting at x_o=656; active_o high for 640 ticks; line_start_o period is 3200 clk_i cycles.
REQ-032 One full frame -> vsync_o low for exactly 2 lines starting at y_o=490; frame_start_o period is 1,680,000 clk_i cycles; y wraps from 524 to 0.
REQ-033 en_i dropped at x_o=700, y_o=100 -> next cycle matches the reset values; en_i restored -> x_o=0, y_o=0 after 4 cycles.
REQ-034 rst_i and en_i pulsed together mid-sync (x_o=700) -> hsync_o=1 next cycle; the sequence restarts exactly as in REQ-030.
REQ-035 CLK_DIV=2 build -> tick period of 2 cycles; all H/V counts identical to the default build.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals and the horizontal/vertical state encodings.
package vga_pkg;

  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned CNT_W   = 10;

  typedef enum logic [1:0] {
    HS_ACT  = 2'd0,
    HS_FP   = 2'd1,
    HS_SYNC = 2'd2,
    HS_BP   = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    VS_ACT  = 2'd0,
    VS_FP   = 2'd1,
    VS_SYNC = 2'd2,
    VS_BP   = 2'd3
  } v_state_e;

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel prescaler. tick_o is registered one cycle ahead of the prescaler wrap so the
// parent can update every pixel-rate register on the wrap edge itself.
module vga_pix_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_d == CW'(CLK_DIV - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel/line counters, H/V phase FSMs and registered sync/active strobes,
// all advancing on the pixel-tick edge.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             pix_tick_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             active_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  localparam int unsigned H_TOT      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_BP_BEG   = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_BP_BEG   = V_SYNC_BEG + V_SYNC;

  logic             tick;
  logic             h_wrap;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  h_state_e         hst_q, hst_d;
  v_state_e         vst_q, vst_d;
  logic             pix_q, pix_d, hs_q, hs_d, vs_q, vs_d;
  logic             act_q, act_d, ls_q, ls_d, fs_q, fs_d;

  vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .tick_o (tick)
  );

  // Next position, phase transitions and strobes; everything holds between ticks.
  always_comb begin
    h_wrap = 1'b0;
    h_d    = h_q;
    v_d    = v_q;
    hst_d  = hst_q;
    vst_d  = vst_q;
    pix_d  = 1'b0;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    hs_d   = hs_q;
    vs_d   = vs_q;
    act_d  = act_q;
    if (tick) begin
      pix_d  = 1'b1;
      h_wrap = (h_q == CNT_W'(H_TOT - 1));
      h_d    = h_wrap ? '0 : h_q + CNT_W'(1);
      case (hst_q)
        HS_ACT:  if (h_d == CNT_W'(H_ACTIVE))   hst_d = HS_FP;
        HS_FP:   if (h_d == CNT_W'(H_SYNC_BEG)) hst_d = HS_SYNC;
        HS_SYNC: if (h_d == CNT_W'(H_BP_BEG))   hst_d = HS_BP;
        HS_BP:   if (h_wrap)                    hst_d = HS_ACT;
        default: hst_d = HS_BP;
      endcase
      if (h_wrap) begin
        v_d = (v_q == CNT_W'(V_TOT - 1)) ? '0 : v_q + CNT_W'(1);
        case (vst_q)
          VS_ACT:  if (v_d == CNT_W'(V_ACTIVE))   vst_d = VS_FP;
          VS_FP:   if (v_d == CNT_W'(V_SYNC_BEG)) vst_d = VS_SYNC;
          VS_SYNC: if (v_d == CNT_W'(V_BP_BEG))   vst_d = VS_BP;
          VS_BP:   if (v_d == '0)                 vst_d = VS_ACT;
          default: vst_d = VS_BP;
        endcase
      end
      hs_d  = (hst_d != HS_SYNC);
      vs_d  = (vst_d != VS_SYNC);
      act_d = (hst_d == HS_ACT) && (vst_d == VS_ACT);
      ls_d  = h_wrap;
      fs_d  = h_wrap && (v_d == '0);
    end
  end

  // Reset and disable both park the raster at the last position of the frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      h_q   <= CNT_W'(H_TOT - 1);
      v_q   <= CNT_W'(V_TOT - 1);
      hst_q <= HS_BP;
      vst_q <= VS_BP;
      pix_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hst_q <= hst_d;
      vst_q <= vst_d;
      pix_q <= pix_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign pix_tick_o    = pix_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign active_o      = act_q;
  assign x_o           = h_q;
  assign y_o           = v_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default 640x480 build and a tiny-raster CLK_DIV=2 build,
// both checked every cycle against an arithmetic raster model, plus literal spot checks.
module tb_vga_timing_ctrl;

  localparam int A_DIV = 4;
  localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2, A_VB = 33;
  localparam int B_DIV = 2;
  localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VA = 4, B_VF = 1, B_VS = 2, B_VB = 2;

  typedef struct packed {
    logic       pix;
    logic       ls;
    logic       fs;
    logic       hsync;
    logic       vsync;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
  } vout_t;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       pix_a, hs_a, vs_a, act_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       pix_b, hs_b, vs_b, act_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;

  always #5 clk = ~clk;

  vga_timing_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .pix_tick_o(pix_a), .hsync_o(hs_a), .vsync_o(vs_a), .active_o(act_a),
    .x_o(x_a), .y_o(y_a), .line_start_o(ls_a), .frame_start_o(fs_a)
  );

  vga_timing_ctrl #(
    .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .pix_tick_o(pix_b), .hsync_o(hs_b), .vsync_o(vs_b), .active_o(act_b),
    .x_o(x_b), .y_o(y_b), .line_start_o(ls_b), .frame_start_o(fs_b)
  );

  int errs = 0;
  int checks = 0;
  int n = 0;
  bit chk_on = 1'b0;

  // n = clock edges since run started; tick t = n/div; raster position is t-1 modulo frame.
  function automatic vout_t model(input int nn, input int div,
                                  input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb);
    vout_t o;
    int ht, vt, nt, t, p, xx, yy;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    nt = ht * vt;
    t  = nn / div;
    p  = (t + nt - 1) % nt;
    xx = p % ht;
    yy = p / ht;
    o.pix   = (nn > 0) && (nn % div == 0);
    o.x     = 10'(xx);
    o.y     = 10'(yy);
    o.hsync = !((xx >= ha + hf) && (xx < ha + hf + hs));
    o.vsync = !((yy >= va + vf) && (yy < va + vf + vs));
    o.act   = (xx < ha) && (yy < va);
    o.ls    = o.pix && (xx == 0);
    o.fs    = o.pix && (p == 0);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input vout_t g, input vout_t e);
    chk({tag, ".pix_tick"},    32'(g.pix),   32'(e.pix));
    chk({tag, ".line_start"},  32'(g.ls),    32'(e.ls));
    chk({tag, ".frame_start"}, 32'(g.fs),    32'(e.fs));
    chk({tag, ".hsync"},       32'(g.hsync), 32'(e.hsync));
    chk({tag, ".vsync"},       32'(g.vsync), 32'(e.vsync));
    chk({tag, ".active"},      32'(g.act),   32'(e.act));
    chk({tag, ".x"},           32'(g.x),     32'(e.x));
    chk({tag, ".y"},           32'(g.y),     32'(e.y));
  endtask

  always @(posedge clk) begin
    if (rst || !en) n <= 0;
    else            n <= n + 1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a", {pix_a, ls_a, fs_a, hs_a, vs_a, act_a, x_a, y_a},
          model(n, A_DIV, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB));
      cmp("b", {pix_b, ls_b, fs_b, hs_b, vs_b, act_b, x_b, y_b},
          model(n, B_DIV, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB));
    end
  end

  task automatic wait_x700(input string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (pix_a && x_a == 10'd700) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  int hs_ticks = 0, hs_x = -1, act_ticks = 0, ls_per = -1, pix_b_cnt = 0;
  int vs_y = -1, vs_cyc = 0;
  int fsb_q[$];
  bit vlow[0:3200];

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst.x", 32'(x_a), 32'd799);
    chk("rst.y", 32'(y_a), 32'd524);
    chk("rst.hsync", 32'(hs_a), 32'd1);
    chk("rst.vsync", 32'(vs_a), 32'd1);
    chk("rst.active", 32'(act_a), 32'd0);
    chk("rst.pix", 32'(pix_a), 32'd0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("first.no_early_tick", 32'(pix_a), 32'd0);
    @(negedge clk);
    chk("first.pix", 32'(pix_a), 32'd1);
    chk("first.x", 32'(x_a), 32'd0);
    chk("first.y", 32'(y_a), 32'd0);
    chk("first.active", 32'(act_a), 32'd1);
    chk("first.frame_start", 32'(fs_a), 32'd1);
    chk("first.line_start", 32'(ls_a), 32'd1);

    // One line of the default build; many frames of the tiny build in the same window.
    for (int c = 0; c <= 3200; c++) begin
      if (c < 3200) begin
        if (pix_a && !hs_a) begin
          if (hs_ticks == 0) hs_x = int'(x_a);
          hs_ticks++;
        end
        if (pix_a && act_a) act_ticks++;
        if (pix_b) pix_b_cnt++;
      end
      if (ls_a && c > 0 && ls_per < 0) ls_per = c;
      if (fs_b) fsb_q.push_back(c);
      vlow[c] = !vs_b;
      if (!vs_b && vs_y < 0) vs_y = int'(y_b);
      @(negedge clk);
    end
    chk("line.hsync_ticks", 32'(hs_ticks), 32'd96);
    chk("line.hsync_start_x", 32'(hs_x), 32'd656);
    chk("line.active_ticks", 32'(act_ticks), 32'd640);
    chk("line.line_start_period", 32'(ls_per), 32'd3200);
    chk("b.tick_count", 32'(pix_b_cnt), 32'd1600);
    chk("b.frame_starts_seen", 32'(fsb_q.size() >= 2), 32'd1);
    if (fsb_q.size() >= 2) begin
      for (int c = fsb_q[0]; c < fsb_q[1]; c++) if (vlow[c]) vs_cyc++;
      chk("b.frame_period", 32'(fsb_q[1] - fsb_q[0]), 32'd270);
      chk("b.vsync_cycles", 32'(vs_cyc), 32'd60);
    end
    chk("b.vsync_start_y", 32'(vs_y), 32'd5);

    // Enable dropped in mid hsync.
    wait_x700("wait.x700_en");
    en = 1'b0;
    @(negedge clk);
    chk("endrop.x", 32'(x_a), 32'd799);
    chk("endrop.y", 32'(y_a), 32'd524);
    chk("endrop.hsync", 32'(hs_a), 32'd1);
    chk("endrop.pix", 32'(pix_a), 32'd0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("enup.no_early_tick", 32'(pix_a), 32'd0);
    @(negedge clk);
    chk("enup.x", 32'(x_a), 32'd0);
    chk("enup.y", 32'(y_a), 32'd0);

    // Reset and disable together, mid hsync.
    wait_x700("wait.x700_rst");
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    chk("rstmid.hsync", 32'(hs_a), 32'd1);
    chk("rstmid.x", 32'(x_a), 32'd799);
    rst = 1'b0;
    en  = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid.restart_x", 32'(x_a), 32'd0);
    chk("rstmid.restart_fs", 32'(fs_a), 32'd1);

    // Random disables and resets at arbitrary raster positions.
    for (int it = 0; it < 16; it++) begin
      repeat ($urandom_range(1, 3000)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: begin
          en = 1'b0;
          repeat ($urandom_range(1, 6)) @(negedge clk);
          en = 1'b1;
        end
        1: begin
          rst = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          rst = 1'b0;
        end
        default: begin
          rst = 1'b1;
          en  = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          en  = 1'b1;
        end
      endcase
    end
    repeat (20) @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
